// File: rtl/rr_arbiter16_pkg.sv
// rr_arbiter16_pkg
// Shared constants and types for the 16-way round-robin arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   state_t : arbiter FSM state
package rr_arbiter16_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter16_pick.sv
// rr_pick
// Combinational round-robin winner search.
//   req    in  16 : request vector
//   ptr    in  4  : index where the search starts
//   winner out 16 : one-hot winner, zero when req is zero
//   idx    out 4  : index of the winner (0 when req is zero)
module rr_pick
  import rr_arbiter16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0]   mask;
  logic [2*N_REQ-1:0] dbl;

  always_comb begin
    mask = {N_REQ{1'b1}} << ptr;
    // Lower copy holds only bits at or above ptr; the upper, unmasked copy
    // supplies the wrapped-around candidates below ptr.
    dbl  = {req, req & mask};
    idx  = '0;
    // Descending scan so the lowest set bit wins; truncating the position
    // to IDX_W bits folds the upper copy back onto 0..15.
    for (int k = 2*N_REQ-1; k >= 0; k--) begin
      if (dbl[k]) idx = IDX_W'(k);
    end
    winner = '0;
    if (|req) winner[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16
// Sixteen-way round-robin arbiter with a registered one-hot grant, grant
// hold timeout and forced-release strobe.
//   HOLD_MAX      param : max grant length in cycles, 0 disables the timeout
//   clk           in  1 : clock
//   rst_n         in  1 : asynchronous active-low reset
//   req           in 16 : level-sensitive request lines
//   release_pulse in  1 : owner ends its grant (one-cycle pulse)
//   grant         out 16: registered one-hot grant or zero
//   grant_valid   out 1 : grant is non-zero
//   timeout       out 1 : one-cycle pulse on forced revocation
//
// state | meaning
// IDLE  | no grant held; next request wins from ptr onward
// BUSY  | grant held; hold counter runs until an end-event
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int HOLD_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             release_pulse,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int CNT_W = ($clog2(HOLD_MAX+1) > 1) ? $clog2(HOLD_MAX+1) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX-1) : '0;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] pick_winner;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_end;
  logic             hold_end;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_winner),
    .idx    (pick_idx)
  );

  assign owner_end = release_pulse | ~|(req & grant);
  assign hold_end  = (HOLD_MAX != 0) && (cnt == CNT_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= pick_winner;
            grant_valid <= 1'b1;
            ptr         <= pick_idx + 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (owner_end || hold_end) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
            // An owner-initiated end hides a coincident timeout.
            timeout     <= hold_end && !owner_end;
          end else if (cnt != {CNT_W{1'b1}}) begin
            // Saturates only when the timeout is disabled.
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Sixteen-way round-robin arbiter that turns a 16-bit request vector into a registered one-hot grant plus a valid strobe. It sits directly upstream of the 16-to-4 binary encoder. `grant` drives the encoder's 16-bit one-hot input and `grant_valid` drives its enable. Because the grant is always exactly one-hot or zero, the encoder never sees an illegal multi-hot input.

## Interface
- `HOLD_MAX`, default 64: maximum cycles a grant may be held before a forced release. A value of 0 disables the timeout.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 16: request lines, level-sensitive; bit i = requester i.
- `release` in 1: one-cycle pulse from the current owner ending its grant.
- `grant` out 16: registered one-hot grant, or all-zero when no grant is held.
- `grant_valid` out 1: high exactly when `grant` is non-zero.
- `timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset values: `grant`=0, `grant_valid`=0, `timeout`=0, pointer `ptr`=0, hold counter=0, state IDLE.
- States:
  - IDLE: no grant held. If `req`≠0, pick a winner, register it into `grant`, set `grant_valid`, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: the grant is held and the hold counter increments each cycle.
- Winner pick: the first set bit of `req` searching from index `ptr` up to 15, then wrapping to 0 through `ptr`-1.
- On a grant to index i, `ptr` is set to (i+1) mod 16, so 15 wraps to 0.
- A BUSY end-event occurs on any of:
  - `release`=1;
  - `req[i]`=0 for the granted index i (requester drops its request);
  - the hold counter reaching `HOLD_MAX`-1 with `HOLD_MAX`≠0 (timeout).
- On an end-event, the next cycle has `grant`=0, `grant_valid`=0, counter=0, and the state returns to IDLE.
- `timeout` pulses only when the timeout is the sole cause of the end-event:
  - `release` or a request drop in the same cycle as the timeout takes precedence, and `timeout` stays 0.
- Requests on other lines while BUSY are ignored; they do not preempt the current grant.
- Counter width is $clog2(HOLD_MAX+1), minimum 1 bit; the counter never wraps.
- `release` while IDLE is ignored.

## Timing
- Grant latency: a request seen in IDLE at edge N produces `grant`/`grant_valid` visible after edge N+1.
- End-event at edge M: grant drops after M+1. At least one IDLE cycle always follows, so the earliest re-grant is after M+2.
- With a continuous request and no release, the grant lasts exactly `HOLD_MAX` cycles.
- `timeout` is high for the single cycle in which `grant` first reads 0.
- Asserting `rst_n` low mid-BUSY clears all outputs immediately, without waiting for a clock edge.
- After `rst_n` deasserts, the first grant is evaluated from `ptr`=0.

## Structure
- Shared package contents:
  - constant `N_REQ`=16;
  - state enum {IDLE, BUSY};
  - index width constant of 4.
- One sub-module, `rr_pick`: purely combinational; takes `req` and `ptr` and returns a one-hot winner plus a 4-bit index.
  - Implement it as a double-width masked priority search.
- The FSM, pointer, counter and output registers stay in `rr_arbiter16`.

## Test plan
- Reset, then `req`=16'h0000 → `grant`=0 and `grant_valid`=0 indefinitely. Then set `req`=16'h0001 at cycle N → `grant`=16'h0001 and `grant_valid`=1 from cycle N+1.
- `req`=16'hFFFF held, `release` pulsed 1 cycle after each grant → grants in order 0001, 0002, 0004 … 8000, then 0001 again (pointer wrap). Each grant is separated by one idle cycle.
- `req`=16'h8001 held, `release` each grant → grants alternate 16'h0001, 16'h8000, 16'h0001, with no starvation.
- `HOLD_MAX`=4, `req`=16'h0010 held, no `release` → `grant`=16'h0010 for exactly 4 cycles, then `grant`=0 with `timeout`=1 for 1 cycle, then re-grant of 16'h0010 the following cycle.
- Timeout precedence and request drop:
  - `release` coinciding with the timeout cycle → `timeout` stays 0.
  - Grant 16'h0004, then `req` dropped to 0 → `grant`=0 the next cycle and `timeout`=0.
- `rst_n` pulled low mid-BUSY (grant 16'h0100, `ptr`=9) → `grant`, `grant_valid` and `timeout` go to 0 asynchronously. With `req`=16'h0300 after release of reset, the first grant is 16'h0100 (`ptr` restored to 0).
